pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub_if.sv | 28 ++
 rtl/pipe_addsub.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// master drives operands and out_ready; slave is the adder pipeline.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit. The WIDTH-bit datapath is cut into STAGES slices;
// stage k adds slice k with group carry-lookahead and hands its carry to stage k+1.
// Each stage register carries the full operands and the partial sum, so every beat
// is independent. Elastic valid/ready handshake with per-stage valid bits.
module pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned GROUP  = 4
) (
    input logic         clk,
    input logic         rst_n,
    input logic         flush,
    pipe_addsub_if.slave bus
);
    localparam int unsigned SW    = WIDTH / STAGES;
    localparam int unsigned NG    = SW / GROUP;
    localparam int          LASTI = int'(STAGES) - 1;

    if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || STAGES > 8 ||
        (WIDTH % STAGES) != 0 || (SW % GROUP) != 0) begin : g_bad_params
        $error("pipe_addsub: illegal WIDTH/STAGES/GROUP combination");
    end

    // Slice adder: lookahead inside each GROUP-bit group, group carries chained.
    // Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          term;
        logic          acc;
        int            base;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        term = 1'b0;
        acc  = 1'b0;
        base = 0;
        for (int gi = 0; gi < int'(NG); gi++) begin
            base = gi * int'(GROUP);
            for (int j = 1; j <= int'(GROUP); j++) begin
                // Carry into bit j of the group, expanded from the group carry-in.
                acc = c[base];
                for (int n = 0; n < j; n++) acc &= p[base+n];
                for (int m = 0; m < j; m++) begin
                    term = g[base+m];
                    for (int n = m + 1; n < j; n++) term &= p[base+n];
                    acc |= term;
                end
                c[base+j] = acc;
            end
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  bx_d [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] adv, ld;
    logic              in_ready;
    logic              accept;
    logic              cout_q, ovf_q, zero_q, neg_q;
    logic              cout_d, ovf_d, zero_d, neg_d;

    // Handshake: a stage loads when empty or when it drains in the same cycle.
    always_comb begin
        adv        = '0;
        ld         = '0;
        adv[LASTI] = vld_q[LASTI] & bus.out_ready;
        ld[LASTI]  = ~vld_q[LASTI] | adv[LASTI];
        for (int k = LASTI - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] & ld[k+1];
            ld[k]  = ~vld_q[k] | adv[k];
        end
        in_ready = rst_n & ~flush & ld[0];
        accept   = bus.in_valid & in_ready;
        vld_d    = vld_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (ld[0]) vld_d[0] = accept;
            for (int k = 1; k <= LASTI; k++) begin
                if (ld[k]) vld_d[k] = vld_q[k-1];
            end
        end
    end

    // Datapath: stage k adds its slice on top of what the previous stage delivered.
    always_comb begin
        logic [WIDTH-1:0] ia, ib, is;
        logic             ic;
        logic [SW:0]      r;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        neg_d  = 1'b0;
        ia     = '0;
        ib     = '0;
        is     = '0;
        ic     = 1'b0;
        r      = '0;
        c_d    = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                // Subtract as a + ~b + 1.
                ia = bus.a;
                ib = bus.sub ? ~bus.b : bus.b;
                is = '0;
                ic = bus.sub;
            end else begin
                ia = a_q[k-1];
                ib = bx_q[k-1];
                is = s_q[k-1];
                ic = c_q[k-1];
            end
            r                    = cla_slice(ia[k*SW +: SW], ib[k*SW +: SW], ic);
            a_d[k]               = ia;
            bx_d[k]              = ib;
            s_d[k]               = is;
            s_d[k][k*SW +: SW]   = r[SW-1:0];
            c_d[k]               = r[SW];
            if (k == LASTI) begin
                cout_d = r[SW];
                ovf_d  = (ia[WIDTH-1] == ib[WIDTH-1]) & (s_d[k][WIDTH-1] != ia[WIDTH-1]);
                zero_d = (s_d[k] == '0);
                neg_d  = s_d[k][WIDTH-1];
            end
        end
    end

    // Stage registers and final-stage flags; a stalled stage holds its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            c_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    a_q[k]  <= a_d[k];
                    bx_q[k] <= bx_d[k];
                    s_q[k]  <= s_d[k];
                    c_q[k]  <= c_d[k];
                end
            end
            if (ld[LASTI]) begin
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_q[LASTI];
    assign bus.s         = s_q[LASTI];
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
endmodule
